// File: rtl/counter_sweep_reader_pkg.sv
// Shared defaults, FSM encoding and the counts_out slice-offset macro for counter_sweep_reader.
`ifndef COUNTER_SWEEP_READER_PKG_SV
`define COUNTER_SWEEP_READER_PKG_SV

// Bit offset of channel i inside a packed bus of w-bit counts.
`define CSR_SLICE(i, w) ((i) * (w))

package counter_sweep_reader_pkg;

   localparam int NUM_CH = 5;
   localparam int CNT_W  = 5;
   localparam int IDX_W  = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_CAP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      WAIT = ST_WAIT,
      CAP  = ST_CAP,
      DONE = ST_DONE
   } state_e;

endpackage

`endif

// File: rtl/counter_sweep_reader_seen.sv
// pop_seen_flags: one sticky flag per channel, set by any pop and cleared only by reset.
module pop_seen_flags #(
   parameter int NUM_CH = counter_sweep_reader_pkg::NUM_CH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] pop_in,
   output logic [NUM_CH-1:0] seen
);

   logic [NUM_CH-1:0] seen_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) seen_q <= '0;
      else       seen_q <= seen_q | pop_in;
   end

   assign seen = seen_q;

endmodule

// File: rtl/counter_sweep_reader.sv
// Sweeps the pop-counter block's idx select, captures every channel and publishes one snapshot.
// Define COUNTER_SWEEP_READER_DELTA_EN to report pops since the last completed sweep instead.
module counter_sweep_reader #(
   parameter int NUM_CH = counter_sweep_reader_pkg::NUM_CH,
   parameter int CNT_W  = counter_sweep_reader_pkg::CNT_W,
   parameter int IDX_W  = counter_sweep_reader_pkg::IDX_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req,
   input  logic                    valid_in,
   input  logic [CNT_W-1:0]        data_in,
   input  logic [NUM_CH-1:0]       pop_in,
   output logic [IDX_W-1:0]        idx,
   output logic                    busy,
   output logic                    done,
   output logic [NUM_CH*CNT_W-1:0] counts_out
);

   import counter_sweep_reader_pkg::*;

   state_e                  state_q;
   logic [IDX_W-1:0]        ch_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    seen_snap_q;
   logic [CNT_W-1:0]        shadow_q [NUM_CH];
   logic [NUM_CH*CNT_W-1:0] counts_q;
   logic [NUM_CH-1:0]       seen;

   logic [CNT_W-1:0]        cap_val_d;
   logic [NUM_CH*CNT_W-1:0] snap_d;
   logic [NUM_CH*CNT_W-1:0] counts_d;

`ifdef COUNTER_SWEEP_READER_DELTA_EN
   logic [CNT_W-1:0]        prev_q [NUM_CH];
`endif

   pop_seen_flags #(.NUM_CH(NUM_CH)) u_seen (
      .clk    (clk),
      .reset  (reset),
      .pop_in (pop_in),
      .seen   (seen)
   );

   // Full snapshot as it will look once the capture in progress lands.
   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      cap_val_d = seen_snap_q ? data_in : '0;
      snap_d    = '0;
      counts_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         snap_d[`CSR_SLICE(i, CNT_W) +: CNT_W] = (IDX_W'(i) == ch_q) ? cap_val_d : shadow_q[i];
`ifdef COUNTER_SWEEP_READER_DELTA_EN
         counts_d[`CSR_SLICE(i, CNT_W) +: CNT_W] =
            snap_d[`CSR_SLICE(i, CNT_W) +: CNT_W] - prev_q[i];
`else
         counts_d[`CSR_SLICE(i, CNT_W) +: CNT_W] = snap_d[`CSR_SLICE(i, CNT_W) +: CNT_W];
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         seen_snap_q <= 1'b0;
         counts_q    <= '0;
         // NOTE: the shadow array is small register state, so it is reset along with everything else.
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
`ifdef COUNTER_SWEEP_READER_DELTA_EN
         for (int i = 0; i < NUM_CH; i++) prev_q[i] <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req && valid_in) begin
                  idx_q   <= '0;
                  ch_q    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (!valid_in) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  seen_snap_q <= seen[ch_q];
                  state_q     <= CAP;
               end
            end
            CAP: begin
               if (!valid_in) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  shadow_q[ch_q] <= cap_val_d;
                  if (ch_q == IDX_W'(NUM_CH - 1)) begin
                     counts_q <= counts_d;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
`ifdef COUNTER_SWEEP_READER_DELTA_EN
                     for (int i = 0; i < NUM_CH; i++)
                        prev_q[i] <= snap_d[`CSR_SLICE(i, CNT_W) +: CNT_W];
`endif
                  end else begin
                     ch_q    <= ch_q + 1'b1;
                     idx_q   <= ch_q + 1'b1;
                     state_q <= WAIT;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               idx_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign idx        = idx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign counts_out = counts_q;

endmodule

// File: tb/tb_counter_sweep_reader.sv
// Scoreboard bench for counter_sweep_reader, with a behavioural pop-counter block as its data source.
module tb_counter_sweep_reader;

   import counter_sweep_reader_pkg::*;

   logic              clk;
   logic              reset;
   logic              req;
   logic              valid_in;
   logic [CNT_W-1:0]  cb_data;
   logic [NUM_CH-1:0] pop_in;
   logic [IDX_W-1:0]  idx;
   logic              busy;
   logic              done;
   logic [24:0]       counts_out;

   int checks   = 0;
   int failures = 0;

   logic [24:0] exp_q [$];
   logic [24:0] tb_prev;
   logic [24:0] last_exp;
   logic [24:0] mon_exp;

   // Counter block: registered read of the selected count; never-popped channels hold a stale value.
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [NUM_CH-1:0] popped;

   counter_sweep_reader dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .valid_in   (valid_in),
      .data_in    (cb_data),
      .pop_in     (pop_in),
      .idx        (idx),
      .busy       (busy),
      .done       (done),
      .counts_out (counts_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         popped  <= '0;
         cb_data <= 5'd21;
      end else begin
         for (int i = 0; i < NUM_CH; i++) if (pop_in[i]) cnt[i] <= cnt[i] + 1'b1;
         popped <= popped | pop_in;
         if (idx < 3'(NUM_CH)) cb_data <= popped[idx] ? cnt[idx] : 5'd21;
         else                  cb_data <= 5'd21;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [24:0] snap(input int c0, input int c1, input int c2,
                                        input int c3, input int c4);
      return {5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
   endfunction

   // Turns the hand-computed absolute counts into what the build should publish.
   task automatic push_expect(input logic [24:0] abs_counts);
      logic [24:0] e;
`ifdef COUNTER_SWEEP_READER_DELTA_EN
      for (int i = 0; i < NUM_CH; i++)
         e[i*CNT_W +: CNT_W] = abs_counts[i*CNT_W +: CNT_W] - tb_prev[i*CNT_W +: CNT_W];
      tb_prev = abs_counts;
`else
      e = abs_counts;
`endif
      last_exp = e;
      exp_q.push_back(e);
   endtask

   // Monitor: every done pulse must match the oldest expected snapshot.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("snapshot", 32'(counts_out), 32'(mon_exp));
         end
      end
   end

   task automatic pop_n(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         pop_in     = '0;
         pop_in[ch] = 1'b1;
      end
      @(negedge clk);
      pop_in = '0;
   endtask

   // One full sweep; optionally pops pop_ch in the cycle following edge N+pop_m.
   task automatic run_sweep(input logic [24:0] abs_counts, input int pop_m, input int pop_ch);
      push_expect(abs_counts);
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      for (int m = 0; m < 12; m++) begin
         if (m > 0) begin
            @(posedge clk);
            #1;
         end
         pop_in = '0;
         if (m == pop_m) pop_in[pop_ch] = 1'b1;
         if (m < 10) begin
            check("sweep_idx", 32'(idx), 32'(m / 2));
            check("sweep_busy", 32'(busy), 32'd1);
            check("sweep_no_early_done", 32'(done), 32'd0);
         end else if (m == 10) begin
            check("done_at_n_plus_10", 32'(done), 32'd1);
         end else begin
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
            check("idx_cleared", 32'(idx), 32'd0);
         end
      end
      pop_in = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, late_done;
      reset    = 1'b1;
      req      = 1'b0;
      valid_in = 1'b1;
      pop_in   = '0;
      tb_prev  = '0;
      last_exp = '0;
      repeat (2) @(negedge clk);
      check("reset_idx", 32'(idx), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_counts", 32'(counts_out), 32'd0);
      reset = 1'b0;

      // Never-popped channels report 0 despite the stale counter output.
      run_sweep(snap(0, 0, 0, 0, 0), -1, 0);

      pop_n(0, 3);
      pop_n(2, 7);
      pop_n(4, 31);
      run_sweep(snap(3, 0, 7, 0, 31), -1, 0);

      // 33 pops wrap to 1 and the channel is seen.
      pop_n(1, 33);
      run_sweep(snap(3, 1, 7, 0, 31), -1, 0);

      // A pop in ch1's WAIT cycle lands after the capture.
      run_sweep(snap(3, 1, 7, 0, 31), 2, 1);
      run_sweep(snap(3, 2, 7, 0, 31), -1, 0);

      // req held high: one done per sweep, 12 cycles apart.
      push_expect(snap(3, 2, 7, 0, 31));
      push_expect(snap(3, 2, 7, 0, 31));
      t0 = -1;
      t1 = -1;
      @(negedge clk);
      req = 1'b1;
      for (int c = 0; c < 40 && t1 < 0; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (t0 < 0) t0 = c;
            else        t1 = c;
         end
      end
      req = 1'b0;
      check("held_req_first_done", 32'(t0), 32'd10);
      check("held_req_spacing", 32'(t1 - t0), 32'd12);
      repeat (2) @(posedge clk);
      #1;
      check("held_req_idle", 32'(busy), 32'd0);

      pop_n(3, 5);
      run_sweep(snap(3, 2, 7, 5, 31), -1, 0);
      pop_n(3, 2);
      run_sweep(snap(3, 2, 7, 7, 31), -1, 0);
      run_sweep(snap(3, 2, 7, 7, 31), -1, 0);

      // valid_in drops during ch2 CAP: abort, previous snapshot stays.
      pop_n(0, 1);
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("abort_pre_idx", 32'(idx), 32'd2);
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_idx", 32'(idx), 32'd0);
      check("abort_counts_hold", 32'(counts_out), 32'(last_exp));
      valid_in  = 1'b1;
      late_done = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (done) late_done++;
      end
      check("abort_no_done", 32'(late_done), 32'd0);
      run_sweep(snap(4, 2, 7, 7, 31), -1, 0);

      // Reset mid-sweep clears outputs immediately.
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_counts", 32'(counts_out), 32'd0);
      check("midreset_idx", 32'(idx), 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      tb_prev = '0;

      // First-ever pop of ch3 during its WAIT cycle is not used for that capture.
      run_sweep(snap(0, 0, 0, 0, 0), 6, 3);
      run_sweep(snap(0, 0, 0, 1, 0), -1, 0);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_sweep_reader.md
Name: counter_sweep_reader

Overview:
- Downstream consumer of the per-channel pop-counter block.
- On a single request, it sweeps the counter block's `idx` select over all channels and waits out the counter block's registered read latency.
- It captures each channel's count and publishes all counts as one atomic snapshot with a one-cycle `done` pulse.
- It also tracks which channels have ever popped, so a never-popped channel reports 0 rather than the stale value the counter block holds on its output.

Parameters:
- NUM_CH, 5, number of counter channels swept.
- CNT_W, 5, width of each count.
- IDX_W, 3, width of the `idx` select driven to the counter block.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  start-sweep request; sampled only in IDLE.
- valid_in  in  1  counter block's `valid` output; its data is usable only while this is high.
- data_in  in  CNT_W  counter block's `data_out`.
- pop_in  in  NUM_CH  the same pop strobes fed to the counter block; bit i is channel i.
- idx  out  IDX_W  channel select to the counter block.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; `counts_out` has just been updated.
- counts_out  out  NUM_CH*CNT_W  snapshot; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - idx=0, busy=0, done=0, counts_out=0.
  - Shadow counts, seen flags, channel pointer ch and seen_snap are all cleared.
- Seen flags:
  - seen[i] is sticky: set on any clock edge where pop_in[i]=1.
  - Cleared only by reset.
- FSM states are IDLE, WAIT, CAP, DONE. All outputs are registered.
- IDLE:
  - If req=1 and valid_in=1: idx<=0, ch<=0, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - seen_snap<=seen[ch], using the pre-edge value so it aligns with the edge at which the counter block samples idx.
  - Go to CAP.
- CAP:
  - shadow[ch] <= seen_snap ? data_in : 0.
  - If ch==NUM_CH-1: go to DONE, counts_out<=all shadows (including this capture), done<=1.
  - Otherwise: ch<=ch+1, idx<=ch+1, go to WAIT.
- DONE:
  - done<=0, idx<=0, go to IDLE.
  - req is ignored in DONE; a new sweep needs req high while in IDLE.
- Latency:
  - Each channel costs 2 cycles.
  - With req accepted at edge N, done and the new counts_out are visible from edge N+2*NUM_CH (edge N+10 at the default).
  - done is high for exactly one cycle.
- req while busy: ignored, with no queuing.
- valid_in low while in WAIT or CAP: abort to IDLE. idx<=0, no done, counts_out unchanged, shadows discarded.
- Pop coinciding with a sweep:
  - A channel captures the counter value as sampled one edge after its idx update.
  - A pop in the WAIT cycle for that channel is not reflected in the capture, and its seen flag is not used for that capture either (seen_snap semantics).
- Counts wrap modulo 2^CNT_W exactly as the counter block does; no saturation.
- Reset mid-sweep: immediate return to IDLE; counts_out clears to 0.

Optional Feature:
- Macro: COUNTER_SWEEP_READER_DELTA_EN.
- Defined:
  - A prev[i] register per channel (reset 0).
  - In DONE, counts_out[i] = (shadow[i]-prev[i]) mod 2^CNT_W, i.e. pops since the last completed sweep.
  - prev[i] <= shadow[i] at that same edge.
  - An aborted sweep leaves prev unchanged.
- Undefined: counts_out carries absolute counts and no prev registers exist.

Decomposition:
- Shared package/include holds:
  - the NUM_CH, CNT_W and IDX_W defaults;
  - the FSM state encoding localparams (IDLE=0, WAIT=1, CAP=2, DONE=3);
  - the counts_out slice-offset macro.
- One sub-module, pop_seen_flags: NUM_CH sticky flags with async reset, pop_in input and seen output bus.

Test Plan:
- No pops since reset; req pulse → done at edge N+10; counts_out=0 on all channels; idx visits 0,1,2,3,4 in that order, each held 2 cycles.
- 3 pops on ch0, 7 on ch2, 31 on ch4, then req → counts_out ch0=3, ch1=0, ch2=7, ch3=0, ch4=31.
- 33 pops on ch1 (wraps) → ch1 reports 1 and is not forced to 0, since seen=1.
- req held high across a full sweep → exactly one done pulse per sweep; pulses are separated by at least the DONE and IDLE cycles; no pulse is generated while busy.
- valid_in dropped during ch2 CAP → return to IDLE, no done, counts_out holds the previous snapshot; reset asserted mid-sweep → busy=0 and counts_out=0 immediately.
- With DELTA_EN: 5 pops on ch3 then sweep → ch3=5; 2 more pops then sweep → ch3=2; no pops then sweep → ch3=0.
